blink_sched: RTL

BLINK_SCHED -- requirements
Module: blink_sched

---
 rtl/blink_pkg.sv | 29 ++
 rtl/blink_sched_if.sv | 42 ++++
 rtl/btn_edge.sv | 25 ++
 rtl/blink_sched.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared types, constants and the blink-period lookup for blink_sched.
// BLINK_PAUSE_EN adds the S_PAUSE state to the state enum.
package blink_pkg;

    localparam int FLASH_SLOW = 1;
    localparam int FLASH_FAST = 2;

    localparam logic [1:0] IDX_MIN = 2'd0;
    localparam logic [1:0] IDX_MAX = 2'd3;

    localparam logic [6:0] PERIOD_BASE = 7'd8;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_ON    = 2'd1
`ifdef BLINK_PAUSE_EN
        , S_PAUSE = 2'd2
`endif
    } state_t;

    // Period in base ticks; index 0 is the 1 s setting in both ranges.
    function automatic logic [6:0] period_ticks(input int flash, input logic [1:0] idx);
        if (flash == FLASH_FAST) begin
            return PERIOD_BASE >> idx;
        end
        return PERIOD_BASE << idx;
    endfunction

endpackage

// File: rtl/blink_sched_if.sv
// Button inputs and blink/shift outputs of blink_sched.
// BLINK_PAUSE_EN adds the btn_pause level.
interface blink_sched_if;

    logic       btn_left;
    logic       btn_right;
    logic       shift_left;
    logic       shift_right;
    logic [1:0] rate_idx;
    logic       led;
    logic       tick;
`ifdef BLINK_PAUSE_EN
    logic       btn_pause;
`endif

    modport master (
`ifdef BLINK_PAUSE_EN
        output btn_pause,
`endif
        output btn_left,
        output btn_right,
        input  shift_left,
        input  shift_right,
        input  rate_idx,
        input  led,
        input  tick
    );

    modport slave (
`ifdef BLINK_PAUSE_EN
        input  btn_pause,
`endif
        input  btn_left,
        input  btn_right,
        output shift_left,
        output shift_right,
        output rate_idx,
        output led,
        output tick
    );

endinterface

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced, clk-synchronous button level.
// A level already high when reset releases is absorbed instead of reported.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic prev;
    logic armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= btn;
            armed <= 1'b1;
        end
    end

    assign rise = btn & ~prev & armed;

endmodule

// File: rtl/blink_sched.sv
// LED blink scheduler: base-tick prescaler, button-driven rate index, blink FSM.
// BLINK_PAUSE_EN adds btn_pause and the S_PAUSE state that freezes the blink.
//
// state   | meaning
// S_OFF   | led low, counting toward the next period wrap
// S_ON    | led high, counting toward the next period wrap
// S_PAUSE | led held at led_hold, prescaler and period counter frozen
module blink_sched
    import blink_pkg::*;
#(
    parameter int FLASH    = FLASH_SLOW,
    parameter int TICK_DIV = 12500000
) (
    input  logic          clk,
    input  logic          rst,
    blink_sched_if.slave  bus
);

    localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_t             state;
    state_t             state_nxt;
    logic [PRE_W-1:0]   pre_cnt;
    logic [6:0]         per_cnt;
    logic [6:0]         period;
    logic [1:0]         rate_idx;
    logic               shift_left_q;
    logic               shift_right_q;
    logic               left_rise;
    logic               right_rise;
    logic               both;
    logic               req_up;
    logic               req_dn;
    logic               acc_up;
    logic               acc_dn;
    logic               rate_chg;
    logic               paused;
    logic               tick_i;
    logic               wrap;
    logic               toggle;
    logic               led_i;

    btn_edge u_edge_left (
        .clk  (clk),
        .rst  (rst),
        .btn  (bus.btn_left),
        .rise (left_rise)
    );

    btn_edge u_edge_right (
        .clk  (clk),
        .rst  (rst),
        .btn  (bus.btn_right),
        .rise (right_rise)
    );

`ifdef BLINK_PAUSE_EN
    logic pause_rise;
    logic led_hold;

    btn_edge u_edge_pause (
        .clk  (clk),
        .rst  (rst),
        .btn  (bus.btn_pause),
        .rise (pause_rise)
    );

    assign paused = (state == S_PAUSE);

    // Captures the level the led would show after this cycle, so a wrap
    // landing on the pause edge is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_hold <= 1'b0;
        end else if (pause_rise && !paused) begin
            led_hold <= (state == S_ON) ^ toggle;
        end
    end
`else
    assign paused = 1'b0;
`endif

    // Rate requests: simultaneous edges cancel, requests at a bound are dropped.
    assign both     = left_rise & right_rise;
    assign req_up   = (FLASH == FLASH_FAST) ? right_rise : left_rise;
    assign req_dn   = (FLASH == FLASH_FAST) ? left_rise  : right_rise;
    assign acc_up   = req_up & ~both & (rate_idx != IDX_MAX);
    assign acc_dn   = req_dn & ~both & (rate_idx != IDX_MIN);
    assign rate_chg = acc_up | acc_dn;

    always_ff @(posedge clk) begin
        if (rst) begin
            rate_idx      <= IDX_MIN;
            shift_left_q  <= 1'b0;
            shift_right_q <= 1'b0;
        end else begin
            shift_left_q  <= left_rise  & rate_chg;
            shift_right_q <= right_rise & rate_chg;
            if (acc_up) begin
                rate_idx <= rate_idx + 2'd1;
            end else if (acc_dn) begin
                rate_idx <= rate_idx - 2'd1;
            end
        end
    end

    assign period = period_ticks(FLASH, rate_idx);
    assign tick_i = (pre_cnt == PRE_LAST) && !paused;
    assign wrap   = tick_i && (per_cnt == period - 7'd1);
    assign toggle = wrap & ~rate_chg;

    // A rate change restarts the period from zero; led keeps its level.
    always_ff @(posedge clk) begin
        if (rst || rate_chg) begin
            pre_cnt <= '0;
            per_cnt <= '0;
        end else if (!paused) begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
            if (tick_i) begin
                per_cnt <= wrap ? 7'd0 : per_cnt + 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_OFF: begin
                if (toggle) state_nxt = S_ON;
            end
            S_ON: begin
                if (toggle) state_nxt = S_OFF;
            end
`ifdef BLINK_PAUSE_EN
            S_PAUSE: begin
                if (pause_rise) state_nxt = led_hold ? S_ON : S_OFF;
            end
`endif
            default: state_nxt = S_OFF;
        endcase
`ifdef BLINK_PAUSE_EN
        if (pause_rise && !paused) state_nxt = S_PAUSE;
`endif
    end

    always_comb begin
        led_i = 1'b0;
        case (state)
            S_ON:    led_i = 1'b1;
`ifdef BLINK_PAUSE_EN
            S_PAUSE: led_i = led_hold;
`endif
            default: led_i = 1'b0;
        endcase
    end

    assign bus.led         = led_i;
    assign bus.tick        = tick_i;
    assign bus.rate_idx    = rate_idx;
    assign bus.shift_left  = shift_left_q;
    assign bus.shift_right = shift_right_q;

endmodule
